// File: rtl/multiplexed_hex_driver_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multiplexed_hex_driver_n                                                 |
// | Time-multiplexed N-digit 7-segment hex driver with PWM brightness,      |
// | double-buffered inputs and leading-zero suppression.                     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module multiplexed_hex_driver_n #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SCAN_DIV  = 65536,
  parameter int unsigned DUTY_BITS = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [4*DIGITS-1:0]   Values,
  input  logic [DIGITS-1:0]     DP,
  input  logic [DIGITS-1:0]     Blank,
  input  logic                  Lz_en,
  input  logic                  Load,
  input  logic [DUTY_BITS-1:0]  Brightness,
  output logic [DIGITS-1:0]     SEG_SEL,
  output logic [7:0]            HEX_OUT,
  output logic                  Frame_done
);

  localparam int unsigned SC_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned D_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned SUB_LEN = SCAN_DIV >> DUTY_BITS;
  localparam int unsigned CMP_W   = SC_W + DUTY_BITS;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);
  localparam logic [D_W-1:0]  D_LAST  = D_W'(DIGITS - 1);

  logic [SC_W-1:0]       sc_q, sc_d;
  logic [D_W-1:0]        d_q, d_d;
  logic                  boundary;

  logic [4*DIGITS-1:0]   sh_val_q, act_val_q;
  logic [DIGITS-1:0]     sh_dp_q, act_dp_q;
  logic [DIGITS-1:0]     sh_blank_q, act_blank_q;
  logic                  sh_lz_q, act_lz_q;

  logic [DIGITS-1:0]     seg_q, seg_d;
  logic [7:0]            hex_q, hex_d;
  logic                  fd_q;

  logic [DIGITS-1:0]     supp;
  logic                  lz_run;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_dark;
  logic [SC_W-1:0]       sub_idx;
  logic                  lit;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    boundary = (sc_q == SC_LAST) && (d_q == D_LAST);
    sc_d     = (sc_q == SC_LAST) ? '0 : sc_q + SC_W'(1);
    d_d      = d_q;
    if (sc_q == SC_LAST) begin
      d_d = (d_q == D_LAST) ? '0 : d_q + D_W'(1);
    end
  end

  // Suppression runs from the top digit down and stops at the first nonzero nibble.
  always_comb begin
    supp   = '0;
    lz_run = act_lz_q;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      lz_run  = lz_run & (act_val_q[4*i +: 4] == 4'd0);
      supp[i] = lz_run;
    end
  end

  always_comb begin
    cur_nib  = 4'd0;
    cur_dp   = 1'b0;
    cur_dark = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (d_q == D_W'(i)) begin
        cur_nib  = act_val_q[4*i +: 4];
        cur_dp   = act_dp_q[i];
        cur_dark = act_blank_q[i] | supp[i];
      end
    end
    sub_idx = sc_q / SC_W'(SUB_LEN);
    lit     = CMP_W'(sub_idx) < CMP_W'(Brightness);

    seg_d = '0;
    hex_d = 8'hFF;
    if (lit && !cur_dark) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        seg_d[i] = (d_q == D_W'(i));
      end
      hex_d = {~cur_dp, hex7(cur_nib)};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sc_q        <= '0;
      d_q         <= '0;
      sh_val_q    <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      sh_lz_q     <= 1'b0;
      act_val_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '0;
      act_lz_q    <= 1'b0;
      seg_q       <= '0;
      hex_q       <= 8'hFF;
      fd_q        <= 1'b0;
    end else begin
      sc_q <= sc_d;
      d_q  <= d_d;
      if (Load) begin
        sh_val_q   <= Values;
        sh_dp_q    <= DP;
        sh_blank_q <= Blank;
        sh_lz_q    <= Lz_en;
      end
      // A Load on the boundary cycle bypasses the shadow straight into the active copy.
      if (boundary) begin
        act_val_q   <= Load ? Values : sh_val_q;
        act_dp_q    <= Load ? DP     : sh_dp_q;
        act_blank_q <= Load ? Blank  : sh_blank_q;
        act_lz_q    <= Load ? Lz_en  : sh_lz_q;
      end
      seg_q <= seg_d;
      hex_q <= hex_d;
      fd_q  <= boundary;
    end
  end

  assign SEG_SEL    = seg_q;
  assign HEX_OUT    = hex_q;
  assign Frame_done = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_multiplexed_hex_driver_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multiplexed_hex_driver_n                                              |
// | Scoreboard bench: stimulus queues per-cycle expectations, monitor checks.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_multiplexed_hex_driver_n;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 16;
  localparam int DUTY_BITS = 2;

  logic                 Clk;
  logic                 Reset;
  logic [4*DIGITS-1:0]  Values;
  logic [DIGITS-1:0]    DP;
  logic [DIGITS-1:0]    Blank;
  logic                 Lz_en;
  logic                 Load;
  logic [DUTY_BITS-1:0] Brightness;
  logic [DIGITS-1:0]    SEG_SEL;
  logic [7:0]           HEX_OUT;
  logic                 Frame_done;

  multiplexed_hex_driver_n #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DUTY_BITS(DUTY_BITS)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Values(Values), .DP(DP), .Blank(Blank),
    .Lz_en(Lz_en), .Load(Load), .Brightness(Brightness),
    .SEG_SEL(SEG_SEL), .HEX_OUT(HEX_OUT), .Frame_done(Frame_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int         k;
    logic [3:0] seg;
    logic [7:0] hex;
    logic       fd;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   cnt;
  int   mon_n;
  int   checks;
  int   passes;

  // Glyph bytes, digit 3 in the top byte, DP bit included (1 = off).
  localparam logic [31:0] G_ZERO = 32'hC0C0C0C0;
  localparam logic [31:0] G_12AF = 32'hF9A4888E;
  localparam logic [31:0] G_0050 = 32'hFFFF12C0;
  localparam logic [31:0] G_2222 = 32'hA4A4A4A4;
  localparam logic [31:0] G_3333 = 32'hB0B0B0B0;

  // cnt = index of the scan state the next rising edge will process.
  always @(posedge Clk) begin
    if (Reset) begin
      mon_n = -1;
      cnt   = 0;
    end else begin
      mon_n = cnt;
      cnt   = cnt + 1;
    end
    #1;
    while (exp_q.size() > 0 && exp_q[0].k >= 0 && exp_q[0].k < mon_n) begin
      checks++;
      $display("FAIL %s k=%0d: check never reached (now at %0d)", exp_q[0].name, exp_q[0].k, mon_n);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].k == mon_n) begin
      checks++;
      if (SEG_SEL === exp_q[0].seg && HEX_OUT === exp_q[0].hex && Frame_done === exp_q[0].fd)
        passes++;
      else
        $display("FAIL %s k=%0d: got seg=%b hex=%h fd=%b, expected seg=%b hex=%h fd=%b",
                 exp_q[0].name, exp_q[0].k, SEG_SEL, HEX_OUT, Frame_done,
                 exp_q[0].seg, exp_q[0].hex, exp_q[0].fd);
      void'(exp_q.pop_front());
    end
  end

  task automatic push_range(input int k0, input int k1, input logic [31:0] glyphs,
                            input logic [3:0] dark, input int b0, input int ksw,
                            input int b1, input string name);
    exp_t e;
    for (int k = k0; k <= k1; k++) begin
      int  slot, d, b;
      logic on;
      slot   = k % SCAN_DIV;
      d      = (k / SCAN_DIV) % DIGITS;
      b      = (k < ksw) ? b0 : b1;
      on     = ((slot / 4) < b) && !dark[d];
      e.k    = k;
      e.seg  = on ? 4'(1 << d) : 4'd0;
      e.hex  = on ? glyphs[8*d +: 8] : 8'hFF;
      e.fd   = ((k % 64) == 63);
      e.name = name;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_reset_check(input string name);
    exp_t e;
    e.k = -1; e.seg = 4'd0; e.hex = 8'hFF; e.fd = 1'b0; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic wait_state(input int k);
    int guard = 0;
    while (cnt != k) begin
      @(negedge Clk);
      guard++;
      if (guard > 5000) begin
        checks++;
        $display("FAIL wait_state k=%0d: timed out at %0d", k, cnt);
        return;
      end
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() > 0) begin
      @(negedge Clk);
      guard++;
      if (guard > 5000) begin
        checks++;
        $display("FAIL drain: %0d checks pending, expected 0", exp_q.size());
        exp_q.delete();
      end
    end
    @(negedge Clk);
  endtask

  // Called on a negedge; reset is sampled on the next two rising edges.
  task automatic do_reset(input logic load_during, input string name);
    push_reset_check(name);
    Reset  = 1'b1;
    Load   = load_during;
    Values = 16'h5555;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    Load  = 1'b0;
  endtask

  task automatic pulse_load(input int k, input logic [15:0] v, input logic [3:0] dp,
                            input logic [3:0] blank, input logic lz);
    wait_state(k);
    Values = v; DP = dp; Blank = blank; Lz_en = lz; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
  endtask

  initial begin
    checks = 0; passes = 0; cnt = 0; mon_n = -1;
    Reset = 1'b1; Values = '0; DP = '0; Blank = '0; Lz_en = 1'b0;
    Load = 1'b0; Brightness = 2'd3;
    repeat (3) @(negedge Clk);

    // Hex glyphs, 12/16 duty, frame pulse every 64 cycles
    Brightness = 2'd3;
    do_reset(1'b0, "rst_a");
    push_range(0, 63, G_ZERO, 4'b0000, 3, 0, 3, "pre_frame_zero");
    push_range(64, 127, G_12AF, 4'b0000, 3, 0, 3, "glyph_12AF");
    pulse_load(0, 16'h12AF, 4'b0000, 4'b0000, 1'b0);
    wait_drain();

    // Leading-zero suppression with a decimal point on digit 1
    do_reset(1'b0, "rst_b");
    push_range(0, 63, G_ZERO, 4'b0000, 3, 0, 3, "pre_frame_zero");
    push_range(64, 127, G_0050, 4'b1100, 3, 0, 3, "lz_0050_dp1");
    pulse_load(0, 16'h0050, 4'b0010, 4'b0000, 1'b1);
    wait_drain();

    // All-zero value: only digit 0 survives, DP of a suppressed digit stays dark
    do_reset(1'b0, "rst_c");
    push_range(0, 63, G_ZERO, 4'b0000, 3, 0, 3, "pre_frame_zero");
    push_range(64, 127, G_ZERO, 4'b1110, 3, 0, 3, "lz_0000");
    pulse_load(0, 16'h0000, 4'b0100, 4'b0000, 1'b1);
    wait_drain();

    // Double buffering: mid-frame loads, last wins; boundary load with a blank
    do_reset(1'b0, "rst_d");
    push_range(0, 63, G_ZERO, 4'b0000, 3, 0, 3, "hold_until_boundary");
    push_range(64, 127, G_2222, 4'b0000, 3, 0, 3, "last_load_2222");
    push_range(128, 191, G_3333, 4'b0010, 3, 0, 3, "boundary_load_3333");
    pulse_load(5, 16'h1111, 4'b0000, 4'b0000, 1'b0);
    pulse_load(30, 16'h2222, 4'b0000, 4'b0000, 1'b0);
    pulse_load(127, 16'h3333, 4'b0000, 4'b0010, 1'b0);
    wait_drain();

    // Brightness 0 is dark; a live change lands within one cycle
    Brightness = 2'd0;
    do_reset(1'b0, "rst_e");
    push_range(0, 127, G_12AF, 4'b0000, 0, 0, 0, "bright0_dark");
    push_range(128, 191, G_12AF, 4'b0000, 0, 134, 3, "bright_live");
    pulse_load(0, 16'h12AF, 4'b0000, 4'b0000, 1'b0);
    wait_state(134);
    Brightness = 2'd3;
    wait_drain();

    // Mid-frame reset at sc=7, d=2 with Load held high during reset
    do_reset(1'b0, "rst_f");
    push_range(0, 63, G_ZERO, 4'b0000, 3, 0, 3, "pre_frame_zero");
    push_range(64, 102, G_12AF, 4'b0000, 3, 0, 3, "before_midreset");
    pulse_load(0, 16'h12AF, 4'b0000, 4'b0000, 1'b0);
    wait_state(103);
    do_reset(1'b1, "midframe_reset");
    push_range(0, 127, G_ZERO, 4'b0000, 3, 0, 3, "cleared_after_reset");
    wait_drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks pending", exp_q.size());
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
